// File: rtl/interface_switch_1to2_if.sv
// interface_switch_1to2_if: received byte stream in, network/ctrl byte streams and statistics out
// Optional o_switch_pending signal exists only when INTERFACE_SWITCH_PENDING_EN is defined.
interface interface_switch_1to2_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 i_interface_type;
    logic [7:0]           iv_data;
    logic                 i_data_wr;
    logic [7:0]           ov_data_network;
    logic                 o_data_wr_network;
    logic [7:0]           ov_data_ctrl;
    logic                 o_data_wr_ctrl;
    logic [CNT_WIDTH-1:0] ov_frame_cnt_network;
    logic [CNT_WIDTH-1:0] ov_frame_cnt_ctrl;
    logic [CNT_WIDTH-1:0] ov_trunc_cnt;
`ifdef INTERFACE_SWITCH_PENDING_EN
    logic                 o_switch_pending;
    modport master (
        output i_interface_type, iv_data, i_data_wr,
        input  ov_data_network, o_data_wr_network, ov_data_ctrl, o_data_wr_ctrl,
        input  ov_frame_cnt_network, ov_frame_cnt_ctrl, ov_trunc_cnt, o_switch_pending
    );
    modport slave (
        input  i_interface_type, iv_data, i_data_wr,
        output ov_data_network, o_data_wr_network, ov_data_ctrl, o_data_wr_ctrl,
        output ov_frame_cnt_network, ov_frame_cnt_ctrl, ov_trunc_cnt, o_switch_pending
    );
`else
    modport master (
        output i_interface_type, iv_data, i_data_wr,
        input  ov_data_network, o_data_wr_network, ov_data_ctrl, o_data_wr_ctrl,
        input  ov_frame_cnt_network, ov_frame_cnt_ctrl, ov_trunc_cnt
    );
    modport slave (
        input  i_interface_type, iv_data, i_data_wr,
        output ov_data_network, o_data_wr_network, ov_data_ctrl, o_data_wr_ctrl,
        output ov_frame_cnt_network, ov_frame_cnt_ctrl, ov_trunc_cnt
    );
`endif
endinterface

// File: rtl/interface_switch_1to2.sv
// interface_switch_1to2: dispatches whole frames to network or ctrl output, truncating at MAX_LEN.
// Define INTERFACE_SWITCH_PENDING_EN to add o_switch_pending (deferred selection change flag).
module interface_switch_1to2 #(
    parameter int MAX_LEN   = 1522,
    parameter int LEN_WIDTH = 11,
    parameter int CNT_WIDTH = 16
) (
    input logic                    i_clk,
    input logic                    i_rst,
    interface_switch_1to2_if.slave bus
);
    localparam logic [1:0] WAIT_GAP = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] FWD      = 2'd2;
    localparam logic [1:0] DISCARD  = 2'd3;
    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);

    logic [1:0]           r_state;
    logic                 r_sel;
    logic [LEN_WIDTH-1:0] r_len;
    logic [7:0]           r_data_net;
    logic [7:0]           r_data_ctrl;
    logic                 r_wr_net;
    logic                 r_wr_ctrl;
    logic [CNT_WIDTH-1:0] r_cnt_net;
    logic [CNT_WIDTH-1:0] r_cnt_ctrl;
    logic [CNT_WIDTH-1:0] r_cnt_trunc;
    logic [1:0]           w_next;
    logic                 w_start;
    logic                 w_fwd;
    logic                 w_trunc;
    logic                 w_eof;
    logic                 w_accept;
    logic                 w_sel;

    always_comb begin
        w_start  = r_state == IDLE && bus.i_data_wr;
        w_fwd    = r_state == FWD && bus.i_data_wr && r_len < MAX_L;
        w_trunc  = r_state == FWD && bus.i_data_wr && r_len >= MAX_L;
        w_eof    = r_state == FWD && !bus.i_data_wr;
        w_accept = w_start || w_fwd;
        // destination is only resampled at start of frame
        w_sel    = w_start ? bus.i_interface_type : r_sel;
        w_next   = !bus.i_data_wr ? IDLE : r_state == IDLE ? FWD : w_trunc ? DISCARD : r_state;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= WAIT_GAP;
            r_sel       <= 1'b0;
            r_len       <= '0;
            r_data_net  <= '0;
            r_data_ctrl <= '0;
            r_wr_net    <= 1'b0;
            r_wr_ctrl   <= 1'b0;
            r_cnt_net   <= '0;
            r_cnt_ctrl  <= '0;
            r_cnt_trunc <= '0;
        end else begin
            r_state     <= w_next;
            r_sel       <= w_sel;
            r_len       <= w_start ? LEN_WIDTH'(1) : w_fwd ? r_len + LEN_WIDTH'(1) : !bus.i_data_wr ? '0 : r_len;
            r_wr_net    <= w_accept && !w_sel;
            r_wr_ctrl   <= w_accept && w_sel;
            r_data_net  <= (w_accept && !w_sel) ? bus.iv_data : '0;
            r_data_ctrl <= (w_accept && w_sel) ? bus.iv_data : '0;
            r_cnt_net   <= r_cnt_net + CNT_WIDTH'(w_eof && !r_sel);
            r_cnt_ctrl  <= r_cnt_ctrl + CNT_WIDTH'(w_eof && r_sel);
            r_cnt_trunc <= r_cnt_trunc + CNT_WIDTH'(w_trunc);
        end
    end

    assign bus.ov_data_network      = r_data_net;
    assign bus.o_data_wr_network    = r_wr_net;
    assign bus.ov_data_ctrl         = r_data_ctrl;
    assign bus.o_data_wr_ctrl       = r_wr_ctrl;
    assign bus.ov_frame_cnt_network = r_cnt_net;
    assign bus.ov_frame_cnt_ctrl    = r_cnt_ctrl;
    assign bus.ov_trunc_cnt         = r_cnt_trunc;

`ifdef INTERFACE_SWITCH_PENDING_EN
    logic r_pending;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_pending <= 1'b0;
        else r_pending <= (r_state == FWD || r_state == DISCARD) && bus.i_interface_type != r_sel;
    end

    assign bus.o_switch_pending = r_pending;
`endif
endmodule

// File: tb/tb_interface_switch_1to2.sv
// tb_interface_switch_1to2: directed frames with hand-computed expectations, plus a CNT_WIDTH=2 wrap instance.
module tb_interface_switch_1to2;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       typ = 1'b0;
    logic       wr  = 1'b0;
    logic [7:0] din = 8'h00;

    always #4 clk = ~clk;

    interface_switch_1to2_if #(.CNT_WIDTH(16)) bus ();
    interface_switch_1to2_if #(.CNT_WIDTH(2))  bus2 ();

    assign bus.i_interface_type  = typ;
    assign bus.iv_data           = din;
    assign bus.i_data_wr         = wr;
    assign bus2.i_interface_type = typ;
    assign bus2.iv_data          = din;
    assign bus2.i_data_wr        = wr;

    interface_switch_1to2 #(.MAX_LEN(1522), .LEN_WIDTH(11), .CNT_WIDTH(16)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );
    interface_switch_1to2 #(.MAX_LEN(1522), .LEN_WIDTH(11), .CNT_WIDTH(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .bus(bus2)
    );

    int         cyc = 0;
    logic [7:0] net_mem [4096];
    logic [7:0] ctrl_mem [4096];
    int         net_cyc [4096];
    int         net_n = 0;
    int         ctrl_n = 0;
    int         viol = 0;
    int         pend_n = 0;
    int         first_drv = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    localparam int NEVER = 32'h7fffffff;

    always @(posedge clk) cyc <= cyc + 1;

    // records every forwarded byte and flags any non-zero idle data or dual-write
    always @(negedge clk) begin
        if (bus.o_data_wr_network === 1'b1) begin
            if (net_n < 4096) begin
                net_mem[net_n] = bus.ov_data_network;
                net_cyc[net_n] = cyc;
            end
            net_n++;
        end else if (bus.o_data_wr_network !== 1'b0 || bus.ov_data_network !== 8'h00) viol++;
        if (bus.o_data_wr_ctrl === 1'b1) begin
            if (ctrl_n < 4096) ctrl_mem[ctrl_n] = bus.ov_data_ctrl;
            ctrl_n++;
        end else if (bus.o_data_wr_ctrl !== 1'b0 || bus.ov_data_ctrl !== 8'h00) viol++;
        if (bus.o_data_wr_network === 1'b1 && bus.o_data_wr_ctrl === 1'b1) viol++;
`ifdef INTERFACE_SWITCH_PENDING_EN
        if (bus.o_switch_pending === 1'b1) pend_n++;
`endif
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int seg_err(input bit c, input int off, input int n, input logic [7:0] base);
        int e = 0;
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = c ? ctrl_mem[off + i] : net_mem[off + i];
            if (v !== 8'(base + i)) e++;
        end
        return e;
    endfunction

    task automatic tick(input logic w, input logic [7:0] d, input logic t);
        @(posedge clk);
        #1;
        wr  = w;
        din = d;
        typ = t;
    endtask

    task automatic frame(input int len, input logic t, input int tog_at, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            tick(1'b1, 8'(base + i), i >= tog_at ? ~t : t);
            if (i == 0) first_drv = cyc;
        end
        tick(1'b0, 8'h00, typ);
    endtask

    task automatic settle;
        tick(1'b0, 8'h00, typ);
        tick(1'b0, 8'h00, typ);
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        rst = 1'b1;
        wr  = 1'b0;
        din = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n0, c0, c1, p0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr", {bus.o_data_wr_network, bus.o_data_wr_ctrl}, 0);
        check("rst_data", {bus.ov_data_network, bus.ov_data_ctrl}, 0);
        check("rst_cnt", {bus.ov_frame_cnt_network, bus.ov_frame_cnt_ctrl, bus.ov_trunc_cnt}, 0);
`ifdef INTERFACE_SWITCH_PENDING_EN
        check("rst_pending", bus.o_switch_pending, 0);
`endif

        do_reset;
        n0 = net_n; c0 = ctrl_n;
        frame(64, 1'b0, NEVER, 8'h00);
        settle;
        check("a_net_len", net_n - n0, 64);
        check("a_net_data", seg_err(0, n0, 64, 8'h00), 0);
        check("a_latency", net_cyc[n0] - first_drv, 1);
        check("a_contiguous", net_cyc[n0 + 63] - net_cyc[n0], 63);
        check("a_ctrl_len", ctrl_n - c0, 0);
        check("a_cnt_net", bus.ov_frame_cnt_network, 1);
        check("a_cnt_ctrl", bus.ov_frame_cnt_ctrl, 0);

        do_reset;
        n0 = net_n; c0 = ctrl_n; p0 = pend_n;
        frame(100, 1'b0, 10, 8'h80);
        frame(20, 1'b1, NEVER, 8'h10);
        settle;
        check("b_net_len", net_n - n0, 100);
        check("b_net_data", seg_err(0, n0, 100, 8'h80), 0);
        check("b_ctrl_len", ctrl_n - c0, 20);
        check("b_ctrl_data", seg_err(1, c0, 20, 8'h10), 0);
        check("b_cnt_net", bus.ov_frame_cnt_network, 1);
        check("b_cnt_ctrl", bus.ov_frame_cnt_ctrl, 1);
`ifdef INTERFACE_SWITCH_PENDING_EN
        check("b_pending_cycles", pend_n - p0, 91);
`endif

        do_reset;
        n0 = net_n; c0 = ctrl_n;
        frame(1600, 1'b1, NEVER, 8'h00);
        settle;
        check("c_ctrl_len", ctrl_n - c0, 1522);
        check("c_ctrl_data", seg_err(1, c0, 1522, 8'h00), 0);
        check("c_trunc", bus.ov_trunc_cnt, 1);
        check("c_cnt_ctrl", bus.ov_frame_cnt_ctrl, 0);
        check("c_net_len", net_n - n0, 0);
        c1 = ctrl_n;
        frame(64, 1'b1, NEVER, 8'h40);
        settle;
        check("c_next_len", ctrl_n - c1, 64);
        check("c_next_data", seg_err(1, c1, 64, 8'h40), 0);
        check("c_next_cnt", bus.ov_frame_cnt_ctrl, 1);
        check("c_next_trunc", bus.ov_trunc_cnt, 1);

        do_reset;
        n0 = net_n; c0 = ctrl_n;
        frame(60, 1'b1, NEVER, 8'hA0);
        frame(60, 1'b0, NEVER, 8'h20);
        settle;
        check("d_ctrl_len", ctrl_n - c0, 60);
        check("d_ctrl_data", seg_err(1, c0, 60, 8'hA0), 0);
        check("d_net_len", net_n - n0, 60);
        check("d_net_data", seg_err(0, n0, 60, 8'h20), 0);
        check("d_cnts", {bus.ov_frame_cnt_network, bus.ov_frame_cnt_ctrl}, {16'd1, 16'd1});

        do_reset;
        n0 = net_n; c0 = ctrl_n;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            rst = (i == 30 || i == 31);
        end
        tick(1'b0, 8'h00, 1'b0);
        frame(20, 1'b0, NEVER, 8'h60);
        settle;
        check("e_net_len", net_n - n0, 50);
        check("e_pre_data", seg_err(0, n0, 30, 8'h00), 0);
        check("e_next_data", seg_err(0, n0 + 30, 20, 8'h60), 0);
        check("e_ctrl_len", ctrl_n - c0, 0);
        check("e_cnt_net", bus.ov_frame_cnt_network, 1);
        check("e_trunc", bus.ov_trunc_cnt, 0);

        do_reset;
        for (int k = 0; k < 5; k++) frame(8, 1'b0, NEVER, 8'(k * 8));
        settle;
        check("f_cnt16", bus.ov_frame_cnt_network, 5);
        check("f_cnt2_wrap", bus2.ov_frame_cnt_network, 1);
        check("idle_zero", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
